vga_line_buffer: RTL and testbench

Double-buffered scanline store between an upstream pixel renderer and the `vga` timing core, on the `CLK25MHZ` pixel clock.
- On each `next_line` pulse it makes the completed back line visible.
- It then immediately requests the following line from the renderer and accepts its pixels over a valid/ready stream.
- Meanwhile it serves the `color_in` value the `vga` core displays for every visible x.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_line_buffer_if.sv | 27 ++
 rtl/vga_line_ram.sv | 38 +++
 rtl/vga_line_buffer.sv | 137 +++++++++++++
 tb/tb_vga_line_buffer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared defaults and types for the VGA scanline buffer.
package vga_pkg;

   localparam int LB_H_ACTIVE = 640;
   localparam int LB_V_ACTIVE = 480;
   localparam int LB_COLOR_W  = 12;
   localparam int LB_Y_W      = 10;

   typedef logic [11:0] color_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL,
      FULL
   } lb_state_t;

endpackage

// File: rtl/vga_line_buffer_if.sv
// Renderer-side bus: line request handshake plus the pixel fill stream.
interface vga_line_buffer_if
   import vga_pkg::*;
#(
   parameter int COLOR_W = LB_COLOR_W,
   parameter int Y_W     = LB_Y_W
);

   logic               req_valid;
   logic [Y_W-1:0]     req_y;
   logic               req_ready;
   logic               wr_valid;
   logic [COLOR_W-1:0] wr_data;
   logic               wr_ready;

   // master = renderer, slave = line buffer
   modport master (
      input  req_valid, req_y, wr_ready,
      output req_ready, wr_valid, wr_data
   );

   modport slave (
      output req_valid, req_y, wr_ready,
      input  req_ready, wr_valid, wr_data
   );

endinterface

// File: rtl/vga_line_ram.sv
// Two-bank scanline RAM: one write port, one registered read port, address {bank, x}.
module vga_line_ram #(
   parameter int H_ACTIVE = 640,
   parameter int COLOR_W  = 12,
   parameter int Y_W      = 10
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [Y_W:0]       wr_addr,
   input  logic [COLOR_W-1:0] wr_data,
   input  logic               rd_en,
   input  logic [Y_W:0]       rd_addr,
   output logic [COLOR_W-1:0] rd_data
);

   localparam int DEPTH = 2 * H_ACTIVE;
   localparam int IDX_W = $clog2(DEPTH);

   logic [COLOR_W-1:0] mem [DEPTH];
   logic [COLOR_W-1:0] rd_data_q;

   // Banks are packed back to back so the array is exactly two lines deep.
   function automatic logic [IDX_W-1:0] flat_idx(input logic [Y_W:0] a);
      return IDX_W'(a[Y_W-1:0]) + (a[Y_W] ? IDX_W'(H_ACTIVE) : '0);
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[flat_idx(wr_addr)] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[flat_idx(rd_addr)];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_line_buffer.sv
// Double-buffered scanline store between a pixel renderer and the VGA timing core.
// Optional VGA_LB_UNDERRUN_COUNT_EN adds a saturating 16-bit underrun counter output.
module vga_line_buffer
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = LB_H_ACTIVE,
   parameter int V_ACTIVE = LB_V_ACTIVE,
   parameter int COLOR_W  = LB_COLOR_W,
   parameter int Y_W      = LB_Y_W
) (
   input  logic               CLK25MHZ,
   input  logic               ck_rst,
   input  logic               next_line,
   input  logic [Y_W-1:0]     next_y,
   input  logic [Y_W-1:0]     rd_x,
   output logic [COLOR_W-1:0] color_in,
   output logic               underrun,
`ifdef VGA_LB_UNDERRUN_COUNT_EN
   output logic [15:0]        underrun_count,
`endif
   vga_line_buffer_if.slave   rnd
);

   lb_state_t          state_q, state_d;
   logic               front_q, front_d;
   logic [Y_W-1:0]     wr_x_q, wr_x_d;
   logic [Y_W-1:0]     req_y_q, req_y_d;
   logic               underrun_q, underrun_d;
   logic               rd_hit_q, rd_hit_d;
   logic               wr_fire;
   logic               last_px;
   logic [COLOR_W-1:0] ram_rd_data;

   assign wr_fire = (state_q == FILL) && rnd.wr_valid;
   assign last_px = (wr_x_q == Y_W'(H_ACTIVE - 1));

   always_comb begin
      state_d    = state_q;
      front_d    = front_q;
      wr_x_d     = wr_x_q;
      req_y_d    = req_y_q;
      underrun_d = 1'b0;
      rd_hit_d   = (rd_x < Y_W'(H_ACTIVE));

      case (state_q)
         IDLE: ;
         REQ: begin
            if (rnd.req_ready) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (rnd.wr_valid) begin
               wr_x_d = wr_x_q + 1'b1;
               if (last_px) begin
                  state_d = FULL;
               end
            end
         end
         FULL: ;
         default: state_d = IDLE;
      endcase

      // A line boundary overrides everything; a final pixel landing this cycle still counts as full.
      if (next_line) begin
         if ((state_q == FULL) || (wr_fire && last_px)) begin
            front_d = ~front_q;
         end else begin
            underrun_d = 1'b1;
         end
         req_y_d = (next_y == Y_W'(V_ACTIVE - 1)) ? '0 : next_y + 1'b1;
         wr_x_d  = '0;
         state_d = REQ;
      end
   end

   always_ff @(posedge CLK25MHZ or posedge ck_rst) begin
      if (ck_rst) begin
         state_q    <= IDLE;
         front_q    <= 1'b0;
         wr_x_q     <= '0;
         req_y_q    <= '0;
         underrun_q <= 1'b0;
         rd_hit_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         front_q    <= front_d;
         wr_x_q     <= wr_x_d;
         req_y_q    <= req_y_d;
         underrun_q <= underrun_d;
         rd_hit_q   <= rd_hit_d;
      end
   end

   vga_line_ram #(
      .H_ACTIVE (H_ACTIVE),
      .COLOR_W  (COLOR_W),
      .Y_W      (Y_W)
   ) u_ram (
      .clk     (CLK25MHZ),
      .wr_en   (wr_fire),
      .wr_addr ({~front_q, wr_x_q}),
      .wr_data (rnd.wr_data),
      .rd_en   (rd_hit_d),
      .rd_addr ({front_q, rd_x}),
      .rd_data (ram_rd_data)
   );

   // RAM output has no reset, so the registered in-range flag forces black after reset and past H_ACTIVE.
   assign color_in      = rd_hit_q ? ram_rd_data : '0;
   assign underrun      = underrun_q;
   assign rnd.req_valid = (state_q == REQ);
   assign rnd.req_y     = req_y_q;
   assign rnd.wr_ready  = (state_q == FILL);

`ifdef VGA_LB_UNDERRUN_COUNT_EN
   logic [15:0] ucount_q, ucount_d;

   always_comb begin
      ucount_d = ucount_q;
      if (underrun_d && (ucount_q != 16'hFFFF)) begin
         ucount_d = ucount_q + 16'd1;
      end
   end

   always_ff @(posedge CLK25MHZ or posedge ck_rst) begin
      if (ck_rst) begin
         ucount_q <= '0;
      end else begin
         ucount_q <= ucount_d;
      end
   end

   assign underrun_count = ucount_q;
`endif

endmodule

// File: tb/tb_vga_line_buffer.sv
// Directed self-checking bench for vga_line_buffer.
module tb_vga_line_buffer;
   import vga_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       next_line;
   logic [9:0] next_y;
   logic [9:0] rd_x;
   color_t     color_in;
   logic       underrun;
`ifdef VGA_LB_UNDERRUN_COUNT_EN
   logic [15:0] underrun_count;
`endif

   vga_line_buffer_if #(.COLOR_W(12), .Y_W(10)) rnd_if ();

   vga_line_buffer dut (
      .CLK25MHZ       (clk),
      .ck_rst         (rst),
      .next_line      (next_line),
      .next_y         (next_y),
      .rd_x           (rd_x),
      .color_in       (color_in),
      .underrun       (underrun),
`ifdef VGA_LB_UNDERRUN_COUNT_EN
      .underrun_count (underrun_count),
`endif
      .rnd            (rnd_if)
   );

   always #20 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int n, input int base);
      for (int x = 0; x < n; x++) begin
         rnd_if.wr_valid = 1'b1;
         rnd_if.wr_data  = 12'(base ^ x);
         tick();
      end
      rnd_if.wr_valid = 1'b0;
   endtask

   task automatic grant;
      rnd_if.req_ready = 1'b1;
      tick();
      rnd_if.req_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      next_line = 1'b0;
      next_y = '0;
      rd_x = '0;
      rnd_if.req_ready = 1'b0;
      rnd_if.wr_valid  = 1'b0;
      rnd_if.wr_data   = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      $display("txn reset release");
      check("rst_req_valid", int'(rnd_if.req_valid), 0);
      check("rst_wr_ready",  int'(rnd_if.wr_ready), 0);
      check("rst_underrun",  int'(underrun), 0);
      check("rst_color",     int'(color_in), 0);
      check("rst_req_y",     int'(rnd_if.req_y), 0);
`ifdef VGA_LB_UNDERRUN_COUNT_EN
      check("rst_ucount",    int'(underrun_count), 0);
`endif

      $display("txn next_line y=0 from IDLE");
      next_line = 1'b1; next_y = 10'd0;
      tick();
      next_line = 1'b0;
      check("l0_underrun",  int'(underrun), 1);
      check("l0_req_valid", int'(rnd_if.req_valid), 1);
      check("l0_req_y",     int'(rnd_if.req_y), 1);
      check("l0_wr_ready",  int'(rnd_if.wr_ready), 0);
      tick();
      check("l0_pulse_end", int'(underrun), 0);
      check("l0_req_hold",  int'(rnd_if.req_valid), 1);

      $display("txn grant + fill 640 px data=x");
      grant();
      check("g1_wr_ready",  int'(rnd_if.wr_ready), 1);
      check("g1_req_drop",  int'(rnd_if.req_valid), 0);
      fill(640, 0);
      check("f1_full_ready", int'(rnd_if.wr_ready), 0);

      $display("txn next_line y=1 swap");
      next_line = 1'b1; next_y = 10'd1;
      tick();
      next_line = 1'b0;
      check("l1_underrun",  int'(underrun), 0);
      check("l1_req_y",     int'(rnd_if.req_y), 2);
      check("l1_req_valid", int'(rnd_if.req_valid), 1);
      rd_x = 10'd5;
      tick();
      check("l1_color_x5",  int'(color_in), 'h005);

      $display("txn next_line y=479 aborts request");
      next_line = 1'b1; next_y = 10'd479;
      tick();
      next_line = 1'b0;
      check("l479_req_y",   int'(rnd_if.req_y), 0);
      check("l479_underrun", int'(underrun), 1);
      tick();
      check("l479_front_kept", int'(color_in), 'h005);

      $display("txn partial fill 300 px then next_line y=10");
      grant();
      fill(300, 'h100);
      next_line = 1'b1; next_y = 10'd10;
      tick();
      next_line = 1'b0;
      check("p_underrun", int'(underrun), 1);
      check("p_req_y",    int'(rnd_if.req_y), 11);
`ifdef VGA_LB_UNDERRUN_COUNT_EN
      check("p_ucount3",  int'(underrun_count), 3);
`endif
      rd_x = 10'd7;
      tick();
      check("p_old_front", int'(color_in), 'h007);

      $display("txn full fill, last px with next_line y=11");
      grant();
      fill(639, 'hA00);
      rnd_if.wr_valid = 1'b1;
      rnd_if.wr_data  = 12'('hA00 ^ 639);
      next_line = 1'b1; next_y = 10'd11;
      tick();
      rnd_if.wr_valid = 1'b0;
      next_line = 1'b0;
      check("c_underrun",  int'(underrun), 0);
      check("c_req_y",     int'(rnd_if.req_y), 12);
      check("c_req_valid", int'(rnd_if.req_valid), 1);
      check("c_wr_ready",  int'(rnd_if.wr_ready), 0);
      rd_x = 10'd0;
      tick();
      check("c_color_x0",   int'(color_in), 'hA00);
      rd_x = 10'd639;
      tick();
      check("c_color_x639", int'(color_in), 'hA00 ^ 639);
      rd_x = 10'd700;
      tick();
      check("c_color_x700", int'(color_in), 0);
      rd_x = 10'd300;
      tick();
      check("c_color_x300", int'(color_in), 'hA00 ^ 300);

      $display("txn next_line y=20 coincident with request handshake");
      rnd_if.req_ready = 1'b1;
      next_line = 1'b1; next_y = 10'd20;
      tick();
      rnd_if.req_ready = 1'b0;
      next_line = 1'b0;
      check("h_req_valid", int'(rnd_if.req_valid), 1);
      check("h_wr_ready",  int'(rnd_if.wr_ready), 0);
      check("h_req_y",     int'(rnd_if.req_y), 21);
      check("h_underrun",  int'(underrun), 1);
      tick();
      check("h_front_kept", int'(color_in), 'hA00 ^ 300);

      $display("txn async reset mid-fill");
      grant();
      fill(10, 'h055);
      rnd_if.wr_valid = 1'b1;
      rd_x = 10'd1;
      tick();
      check("r_pre_color",    int'(color_in), 'hA01);
      check("r_pre_wr_ready", int'(rnd_if.wr_ready), 1);
      #5;
      rst = 1'b1;
      #1;
      check("r_wr_ready",  int'(rnd_if.wr_ready), 0);
      check("r_req_valid", int'(rnd_if.req_valid), 0);
      check("r_req_y",     int'(rnd_if.req_y), 0);
      check("r_color",     int'(color_in), 0);
      check("r_underrun",  int'(underrun), 0);
`ifdef VGA_LB_UNDERRUN_COUNT_EN
      check("r_ucount",    int'(underrun_count), 0);
`endif
      rnd_if.wr_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
